// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture block and the display driver.
// Holds the active-low hex segment patterns (seg[0]=a ... seg[6]=g), the
// capture FSM state encoding and the anode helper functions.
package seg7_pkg;

  // Active-low segment patterns for hex digits 0..F, indexed by nibble value.
  localparam logic [6:0] SegTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StHold   = 2'd2
  } state_e;

  // Anodes are active-low; exactly one driven digit is a legal frame slot.
  function automatic logic an_legal(input logic [3:0] an);
    return ($countones(~an) == 1);
  endfunction

  // Slot index of the single active anode; only meaningful when an_legal().
  function automatic logic [1:0] an_index(input logic [3:0] an);
    case (an)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Encoder used by the display driver, sharing the same table.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SegTable[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment decoder.
// Ports:
//   i_seg    - active-low segment pattern, seg[0]=a ... seg[6]=g
//   o_legal  - 1 when i_seg matches one of the 16 hex patterns
//   o_nibble - decoded hex value (0 when not legal)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_legal,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_legal  = 1'b0;
    o_nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SegTable[i]) begin
        o_legal  = 1'b1;
        o_nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_7_capture.sv
// Reconstructs the hex value shown on a multiplexed 4-digit 7-segment display
// by watching its anode/segment/dp lines.
// Ports:
//   clk, rst_n       - system clock, synchronous active-low reset
//   seg[6:0], dp     - active-low segment bus and decimal point
//   an[3:0]          - active-low anodes, an[0] = least-significant digit
//   x_out[15:0]      - captured value, digit k in x_out[4k+3:4k]
//   dp_out[3:0]      - captured decimal points, 1 = lit
//   valid            - x_out holds a complete, non-timed-out frame
//   frame_done       - one-cycle pulse when x_out is updated
//   err              - one-cycle pulse when a settled digit has an illegal pattern
module seg_7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,  // must be >= 2
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [15:0] x_out,
  output logic [3:0]  dp_out,
  output logic        valid,
  output logic        frame_done,
  output logic        err
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [6:0]    r_seg, r_seg_p;
  logic [3:0]    r_an, r_an_p;
  logic          r_dp, r_dp_p;
  state_e        r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [ToW-1:0]  r_to_cnt, w_to_cnt_d;
  logic [3:0]    r_seen, w_seen_d;
  logic [15:0]   r_slot_x, w_slot_x_d;
  logic [3:0]    r_slot_dp, w_slot_dp_d;
  logic [15:0]   r_x, w_x_d;
  logic [3:0]    r_dpo, w_dpo_d;
  logic          r_valid, w_valid_d;
  logic          r_fd, w_fd_d;
  logic          r_err, w_err_d;

  logic          w_legal;
  logic [3:0]    w_nibble;
  logic          w_an_ok, w_same, w_sample, w_samp_ok;
  logic [1:0]    w_idx;

  seg7_decode u_decode (
    .i_seg    (r_seg),
    .o_legal  (w_legal),
    .o_nibble (w_nibble)
  );

  assign w_an_ok   = an_legal(r_an);
  assign w_idx     = an_index(r_an);
  assign w_same    = (r_an == r_an_p) && (r_seg == r_seg_p) && (r_dp == r_dp_p);
  assign w_samp_ok = w_sample && w_legal;

  // Capture FSM: counter holds the number of stable cycles seen so far; the
  // sample fires on the clock where it would reach SETTLE_CYCLES-1.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_sample  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_an_ok) begin
          w_state_d = StSettle;
          w_cnt_d   = '0;
        end
      end
      StSettle: begin
        if (!w_an_ok) begin
          w_state_d = StIdle;
        end else if (!w_same) begin
          w_cnt_d = '0;
        end else if (r_cnt == CntW'(SETTLE_CYCLES - 2)) begin
          w_sample  = 1'b1;
          w_state_d = StHold;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StHold: begin
        // Only an anode change leaves HOLD; segment changes are ignored.
        if (r_an != r_an_p) begin
          w_state_d = w_an_ok ? StSettle : StIdle;
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_seen_d    = r_seen;
    w_slot_x_d  = r_slot_x;
    w_slot_dp_d = r_slot_dp;
    w_x_d       = r_x;
    w_dpo_d     = r_dpo;
    w_valid_d   = r_valid;
    w_fd_d      = 1'b0;
    w_err_d     = w_sample && !w_legal;
    w_to_cnt_d  = r_to_cnt;

    if (r_seen == 4'hF) begin
      w_x_d     = r_slot_x;
      w_dpo_d   = r_slot_dp;
      w_fd_d    = 1'b1;
      w_valid_d = 1'b1;
      w_seen_d  = 4'h0;
    end

    // Saturating idle counter; expiry drops valid and any partial frame.
    if (w_samp_ok) begin
      w_to_cnt_d = '0;
    end else if (r_to_cnt != ToW'(TIMEOUT_CYCLES)) begin
      w_to_cnt_d = r_to_cnt + ToW'(1);
      if (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1)) begin
        w_valid_d = 1'b0;
        w_seen_d  = 4'h0;
      end
    end

    if (w_samp_ok) begin
      w_slot_x_d[{w_idx, 2'b00} +: 4] = w_nibble;
      w_slot_dp_d[w_idx]              = ~r_dp;
      w_seen_d[w_idx]                 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg     <= 7'h7F;
      r_seg_p   <= 7'h7F;
      r_an      <= 4'hF;
      r_an_p    <= 4'hF;
      r_dp      <= 1'b1;
      r_dp_p    <= 1'b1;
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_to_cnt  <= '0;
      r_seen    <= 4'h0;
      r_slot_x  <= 16'h0000;
      r_slot_dp <= 4'h0;
      r_x       <= 16'h0000;
      r_dpo     <= 4'h0;
      r_valid   <= 1'b0;
      r_fd      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_seg     <= seg;
      r_seg_p   <= r_seg;
      r_an      <= an;
      r_an_p    <= r_an;
      r_dp      <= dp;
      r_dp_p    <= r_dp;
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_to_cnt  <= w_to_cnt_d;
      r_seen    <= w_seen_d;
      r_slot_x  <= w_slot_x_d;
      r_slot_dp <= w_slot_dp_d;
      r_x       <= w_x_d;
      r_dpo     <= w_dpo_d;
      r_valid   <= w_valid_d;
      r_fd      <= w_fd_d;
      r_err     <= w_err_d;
    end
  end

  assign x_out      = r_x;
  assign dp_out     = r_dpo;
  assign valid      = r_valid;
  assign frame_done = r_fd;
  assign err        = r_err;

endmodule
